// File: rtl/mbist_mem_scheduler_pkg.sv
// Shared types and defaults for the MBIST memory scheduler.
// Holds the FSM state encoding and the index-width helper used by the top and the watchdog.
package mbist_mem_scheduler_pkg;

    localparam int MEM_NUM_DEFAULT = 4;

    // Width needed to hold values 0..n-1; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int MEM_IDX_W_DEFAULT = idx_width(MEM_NUM_DEFAULT);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SCAN,
        ST_SETTLE,
        ST_KICK,
        ST_WAIT,
        ST_FINISH
    } sched_state_t;

endpackage

// File: rtl/mbist_sched_wdog.sv
// WAIT-state watchdog for the MBIST scheduler.
// It is instantiated only when MBIST_TIMEOUT_EN is defined.
module mbist_sched_wdog
    import mbist_mem_scheduler_pkg::*;
#(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int CNT_W = idx_width(TIMEOUT_CYC);

    logic [CNT_W-1:0] cnt;

    // The count parks on the last value once expired, so it cannot wrap before the next clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (run && !expired) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign expired = run && (cnt == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/mbist_mem_scheduler.sv
// Sequences one pmbist engine across MEM_NUM memory collars and builds a per-memory pass/fail map.
// Define MBIST_TIMEOUT_EN to add the WAIT watchdog and the timeout_map reporting.
module mbist_mem_scheduler
    import mbist_mem_scheduler_pkg::*;
#(
    parameter int MEM_NUM     = MEM_NUM_DEFAULT,
    parameter int SETTLE_CYC  = 2,
    parameter int TIMEOUT_CYC = 64,
    localparam int MEM_IDX_W  = idx_width(MEM_NUM)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic [MEM_NUM-1:0]   mem_en,
    output logic                 eng_start,
    input  logic                 eng_done,
    input  logic [MEM_NUM-1:0]   fail_flags,
    output logic [MEM_NUM-1:0]   mem_sel,
    output logic                 mbist_run,
    output logic [MEM_IDX_W-1:0] cur_idx,
    output logic                 busy,
    output logic                 done,
    output logic [MEM_NUM-1:0]   fail_map,
    output logic [MEM_NUM-1:0]   timeout_map
);

    localparam int SET_W = idx_width(SETTLE_CYC);

    sched_state_t         state;
    sched_state_t         next_state;
    logic [MEM_IDX_W-1:0] idx;
    logic [SET_W-1:0]     settle_cnt;
    logic [MEM_NUM-1:0]   mem_en_q;
    logic                 last_idx;
    logic                 settle_last;
    logic                 timed_out;
    logic                 wait_exit;

    assign last_idx    = (idx == MEM_IDX_W'(MEM_NUM - 1));
    assign settle_last = (settle_cnt == SET_W'(SETTLE_CYC - 1));

`ifdef MBIST_TIMEOUT_EN
    logic wdog_clear;
    logic wdog_run;

    assign wdog_clear = (state == ST_KICK);
    assign wdog_run   = (state == ST_WAIT);

    mbist_sched_wdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk    (clk),
        .rst    (rst),
        .clear  (wdog_clear),
        .run    (wdog_run),
        .expired(timed_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timeout_map <= '0;
        end else if (state == ST_IDLE && start && !abort) begin
            timeout_map <= '0;
        end else if (state == ST_WAIT && wait_exit && !abort) begin
            timeout_map[idx] <= timed_out;
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timed_out          = 1'b0;
    assign timeout_map        = '0;
`endif

    assign wait_exit = eng_done || timed_out;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // abort overrides every transition, including a same-cycle eng_done in WAIT.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_SCAN;
            ST_SCAN: begin
                if (mem_en_q[idx]) begin
                    next_state = ST_SETTLE;
                end else if (last_idx) begin
                    next_state = ST_FINISH;
                end
            end
            ST_SETTLE: if (settle_last) next_state = ST_KICK;
            ST_KICK:   next_state = ST_WAIT;
            ST_WAIT: begin
                if (wait_exit) begin
                    next_state = last_idx ? ST_FINISH : ST_SCAN;
                end
            end
            ST_FINISH: next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (abort) begin
            next_state = ST_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            settle_cnt <= '0;
            mem_en_q   <= '0;
            fail_map   <= '0;
        end else if (abort) begin
            idx        <= '0;
            settle_cnt <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx      <= '0;
                        mem_en_q <= mem_en;
                        fail_map <= '0;
                    end
                end
                ST_SCAN: begin
                    settle_cnt <= '0;
                    if (!mem_en_q[idx] && !last_idx) begin
                        idx <= idx + MEM_IDX_W'(1);
                    end
                end
                ST_SETTLE: settle_cnt <= settle_cnt + SET_W'(1);
                ST_WAIT: begin
                    if (wait_exit) begin
                        fail_map[idx] <= fail_flags[idx] || timed_out;
                        if (!last_idx) begin
                            idx <= idx + MEM_IDX_W'(1);
                        end
                    end
                end
                ST_FINISH: idx <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem_sel   = '0;
        mbist_run = 1'b0;
        eng_start = 1'b0;
        busy      = (state != ST_IDLE);
        done      = (state == ST_FINISH);
        if (state == ST_SETTLE || state == ST_KICK || state == ST_WAIT) begin
            mem_sel   = MEM_NUM'(1) << idx;
            mbist_run = 1'b1;
        end
        if (state == ST_KICK) begin
            eng_start = 1'b1;
        end
    end

    assign cur_idx = idx;

endmodule
